// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - PS/2 scan-code prefix decoder with modifier tracking and event FIFO
//
// Decodes the raw PS/2 byte stream (E0/F0/E1 prefixes) into make/break key
// events, tracks shift/ctrl/caps-lock state and queues tagged events in a
// show-ahead FIFO read through a valid/ready handshake.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rx_data             byte from the PS/2 receiver, valid with rx_done_tick
//   rx_done_tick        one-cycle strobe per received byte
//   evt_valid/ready     FIFO head handshake (pop on valid & ready)
//   evt_code            scan code of the head event, prefixes stripped
//   evt_extended        head event was E0-prefixed
//   evt_release         head event is a break
//   evt_shift/ctrl/caps modifier state captured when the event was pushed
//   caps_lock           live caps-lock toggle state
//   fifo_count          entries held
//   overflow            sticky drop flag, cleared by overflow_clr
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter bit EMIT_BREAK = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done_tick,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_extended,
    output logic                          evt_release,
    output logic                          evt_shift,
    output logic                          evt_ctrl,
    output logic                          evt_caps,
    output logic                          caps_lock,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;
    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_CTRL   = 8'h14;
    localparam logic [7:0] KEY_CAPS   = 8'h58;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  skip_q, skip_d;

    logic        dec_valid;
    logic        dec_ext;
    logic        dec_rel;

    logic        lshift_q, lshift_d, rshift_q, rshift_d;
    logic        lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic        caps_q, caps_d, caps_held_q, caps_held_d;
    logic        push;

    logic [12:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;
    logic          empty, full, pop, wr_en, drop;
    logic [12:0]   entry, head;

    // Prefix decoder: yields one decoded key (dec_*) on the byte that completes it.
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        dec_valid = 1'b0;
        dec_ext   = 1'b0;
        dec_rel   = 1'b0;
        if (rx_done_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == PFX_EXT) begin
                        state_d = S_EXT;
                    end else if (rx_data == PFX_BRK) begin
                        state_d = S_BRK;
                    end else if (rx_data == PFX_PAUSE) begin
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end else begin
                        dec_valid = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_data == PFX_BRK) begin
                        state_d = S_EXT_BRK;
                    end else if (rx_data != PFX_EXT) begin
                        dec_valid = 1'b1;
                        dec_ext   = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_BRK: begin
                    dec_valid = 1'b1;
                    dec_rel   = 1'b1;
                    state_d   = S_IDLE;
                end
                S_EXT_BRK: begin
                    dec_valid = 1'b1;
                    dec_ext   = 1'b1;
                    dec_rel   = 1'b1;
                    state_d   = S_IDLE;
                end
                S_SKIP: begin
                    // Pause sequence: swallow the 7 bytes that follow E1.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Modifier tracking; modifier keys never reach the FIFO.
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        push        = 1'b0;
        if (dec_valid) begin
            if (rx_data == KEY_LSHIFT || rx_data == KEY_RSHIFT) begin
                // E0-prefixed shifts are synthetic and dropped entirely.
                if (!dec_ext) begin
                    if (rx_data == KEY_LSHIFT) lshift_d = !dec_rel;
                    else                       rshift_d = !dec_rel;
                end
            end else if (rx_data == KEY_CTRL) begin
                if (dec_ext) rctrl_d = !dec_rel;
                else         lctrl_d = !dec_rel;
            end else if (rx_data == KEY_CAPS && !dec_ext) begin
                if (dec_rel) begin
                    caps_held_d = 1'b0;
                end else if (!caps_held_q) begin
                    caps_d      = !caps_q;
                    caps_held_d = 1'b1;
                end
            end else begin
                push = !dec_rel || EMIT_BREAK;
            end
        end
    end

    assign entry = {caps_q, lctrl_q | rctrl_q, lshift_q | rshift_q, dec_rel, dec_ext, rx_data};

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = !empty && evt_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (!wr_en && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            skip_q      <= 3'd0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            count_q     <= count_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)              overflow_q <= 1'b1;
            else if (overflow_clr) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= entry;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign head         = empty ? 13'd0 : mem_q[rd_ptr_q];
    assign evt_valid    = !empty;
    assign evt_code     = head[7:0];
    assign evt_extended = head[8];
    assign evt_release  = head[9];
    assign evt_shift    = head[10];
    assign evt_ctrl     = head[11];
    assign evt_caps     = head[12];
    assign caps_lock    = caps_q;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;

endmodule
